// File: rtl/issue_scoreboard.sv
// issue_scoreboard: in-order issue / out-of-order writeback / in-order commit buffer.
// Define SB_FORWARD_EN to enable youngest-first operand forwarding lookups.
package issue_scoreboard_pkg;
    localparam int unsigned NR_SB_ENTRIES = 4;
    localparam int unsigned NR_WB_PORTS   = 3;
    localparam int unsigned TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);
    localparam logic [63:0] ILLEGAL_INSTR = 64'd2;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

    typedef struct packed {
        logic [63:0]              pc;
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [3:0]               fu;
        logic [6:0]               op;
        logic [4:0]               rs1;
        logic [4:0]               rs2;
        logic [4:0]               rd;
        logic [63:0]              result;
        logic                     valid;
        logic                     use_imm;
        exception_t               ex;
    } scoreboard_entry_t;
endpackage

module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = NR_SB_ENTRIES,
    parameter int unsigned NR_WB      = NR_WB_PORTS,
    localparam int unsigned IDW = $clog2(NR_ENTRIES),
    localparam int unsigned SBW = $bits(scoreboard_entry_t),
    localparam int unsigned EXW = $bits(exception_t)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           flush_i,
    input  logic [SBW-1:0]                 issue_entry_i,
    input  logic                           issue_valid_i,
    output logic                           issue_ready_o,
    output logic [IDW-1:0]                 issue_trans_id_o,
    input  logic [NR_WB-1:0]               wb_valid_i,
    input  logic [NR_WB-1:0][IDW-1:0]      wb_trans_id_i,
    input  logic [NR_WB-1:0][63:0]         wb_result_i,
    input  logic [NR_WB-1:0][EXW-1:0]      wb_ex_i,
    output logic [SBW-1:0]                 commit_entry_o,
    output logic                           commit_valid_o,
    input  logic                           commit_ack_i,
    input  logic [4:0]                     rs1_i,
    input  logic [4:0]                     rs2_i,
    output logic [63:0]                    rs1_o,
    output logic [63:0]                    rs2_o,
    output logic                           rs1_valid_o,
    output logic                           rs2_valid_o
);
    scoreboard_entry_t             mem_q [NR_ENTRIES];
    logic [NR_ENTRIES-1:0]         alloc_q;
    logic [IDW-1:0]                head_q, tail_q;
    logic [IDW:0]                  count_q;
    scoreboard_entry_t             ie, new_e;
    exception_t [NR_WB-1:0]        wb_ex;
    logic                          issue_fire, commit_fire;

    assign ie               = issue_entry_i;
    assign wb_ex            = wb_ex_i;
    assign issue_ready_o    = count_q != (IDW+1)'(NR_ENTRIES);
    assign issue_trans_id_o = tail_q;
    assign commit_entry_o   = mem_q[head_q];
    assign commit_valid_o   = alloc_q[head_q] && mem_q[head_q].valid;
    assign issue_fire       = issue_valid_i && issue_ready_o;
    assign commit_fire      = commit_ack_i && commit_valid_o;

    // Entries carrying a decode exception are born valid so they commit without writeback.
    always_comb begin
        new_e          = ie;
        new_e.trans_id = TRANS_ID_BITS'(tail_q);
        new_e.valid    = ie.ex.valid;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            alloc_q <= '0;
            for (int i = 0; i < NR_ENTRIES; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            alloc_q <= '0;
            for (int i = 0; i < NR_ENTRIES; i++) mem_q[i].valid <= 1'b0;
        end else begin
            if (issue_fire) begin
                mem_q[tail_q]   <= new_e;
                alloc_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + 1'b1;
            end
            // Descending order so the lowest port wins on a (forbidden) collision.
            for (int k = int'(NR_WB) - 1; k >= 0; k--) begin
                if (wb_valid_i[k] && alloc_q[wb_trans_id_i[k]]) begin
                    mem_q[wb_trans_id_i[k]].result <= wb_result_i[k];
                    mem_q[wb_trans_id_i[k]].valid  <= 1'b1;
                    if (wb_ex[k].valid) mem_q[wb_trans_id_i[k]].ex <= wb_ex[k];
                end
            end
            if (commit_fire) begin
                alloc_q[head_q]     <= 1'b0;
                mem_q[head_q].valid <= 1'b0;
                head_q              <= head_q + 1'b1;
            end
            count_q <= count_q + (IDW+1)'(issue_fire) - (IDW+1)'(commit_fire);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            for (int k = 0; k < NR_WB; k++)
                for (int j = k + 1; j < NR_WB; j++)
                    assert (!(wb_valid_i[k] && wb_valid_i[j] && wb_trans_id_i[k] == wb_trans_id_i[j]));
        end
    end

`ifdef SB_FORWARD_EN
    logic [IDW-1:0] idx;

    // Walk oldest to youngest so the youngest match overwrites earlier ones.
    always_comb begin
        idx         = '0;
        rs1_o       = '0;
        rs2_o       = '0;
        rs1_valid_o = 1'b0;
        rs2_valid_o = 1'b0;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            idx = head_q + IDW'(i);
            if (alloc_q[idx] && rs1_i != 5'd0 && mem_q[idx].rd == rs1_i) begin
                rs1_o       = mem_q[idx].result;
                rs1_valid_o = mem_q[idx].valid && !mem_q[idx].ex.valid;
            end
            if (alloc_q[idx] && rs2_i != 5'd0 && mem_q[idx].rd == rs2_i) begin
                rs2_o       = mem_q[idx].result;
                rs2_valid_o = mem_q[idx].valid && !mem_q[idx].ex.valid;
            end
        end
    end
`else
    logic unused_rs;

    assign unused_rs   = ^{rs1_i, rs2_i};
    assign rs1_o       = '0;
    assign rs2_o       = '0;
    assign rs1_valid_o = 1'b0;
    assign rs2_valid_o = 1'b0;
`endif
endmodule

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard: directed and randomized checks against a queue-based commit-order model.
module tb_issue_scoreboard;
    import issue_scoreboard_pkg::*;

    localparam int N   = 4;
    localparam int W   = 3;
    localparam int IDW = 2;

    typedef struct {
        int          id;
        logic [4:0]  rd;
        logic [63:0] pc;
        logic [63:0] res;
        bit          vld;
        exception_t  ex;
    } m_t;

    logic clk_i = 0, rst_ni = 0, flush_i = 0, issue_valid_i = 0, commit_ack_i = 0;
    scoreboard_entry_t       ie, ce;
    logic                    issue_ready_o;
    logic [IDW-1:0]          issue_trans_id_o;
    logic [W-1:0]            wb_valid_i;
    logic [W-1:0][IDW-1:0]   wb_trans_id_i;
    logic [W-1:0][63:0]      wb_result_i;
    exception_t [W-1:0]      wb_ex_i;
    logic                    commit_valid_o;
    logic [4:0]              rs1_i, rs2_i;
    logic [63:0]             rs1_o, rs2_o;
    logic                    rs1_valid_o, rs2_valid_o;

    m_t q[$];
    int nid = 0;
    int checks = 0, errors = 0;

    issue_scoreboard #(.NR_ENTRIES(N), .NR_WB(W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .issue_entry_i(ie), .issue_valid_i(issue_valid_i),
        .issue_ready_o(issue_ready_o), .issue_trans_id_o(issue_trans_id_o),
        .wb_valid_i(wb_valid_i), .wb_trans_id_i(wb_trans_id_i),
        .wb_result_i(wb_result_i), .wb_ex_i(wb_ex_i),
        .commit_entry_o(ce), .commit_valid_o(commit_valid_o), .commit_ack_i(commit_ack_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rs1_o(rs1_o), .rs2_o(rs2_o),
        .rs1_valid_o(rs1_valid_o), .rs2_valid_o(rs2_valid_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        flush_i = 0; issue_valid_i = 0; commit_ack_i = 0;
        ie = '0; wb_valid_i = '0; wb_trans_id_i = '0; wb_result_i = '0; wb_ex_i = '0;
        rs1_i = 0; rs2_i = 0;
    endtask

    task automatic set_issue(input logic [4:0] rd, input bit exv, input logic [63:0] cause);
        issue_valid_i = 1;
        ie = '0;
        ie.pc = {32'h8000_0000, $urandom};
        ie.rd = rd;
        ie.result = 64'($urandom_range(0, 255));
        ie.valid = 1'($urandom);
        ie.trans_id = 2'($urandom);
        ie.ex.valid = exv;
        ie.ex.cause = cause;
    endtask

    task automatic set_wb(input int k, input int id, input logic [63:0] res);
        wb_valid_i[k] = 1;
        wb_trans_id_i[k] = IDW'(id);
        wb_result_i[k] = res;
        wb_ex_i[k] = '0;
    endtask

    task automatic fwd_exp(input logic [4:0] rs, output logic [63:0] v, output logic ok);
        v = 0; ok = 0;
`ifdef SB_FORWARD_EN
        if (rs != 0)
            for (int i = q.size() - 1; i >= 0; i--)
                if (q[i].rd == rs) begin
                    v = q[i].res; ok = q[i].vld && !q[i].ex.valid;
                    break;
                end
`endif
    endtask

    task automatic check_all();
        logic [63:0] v;
        logic ok;
        bit cv;
        cv = q.size() > 0 && q[0].vld;
        chk("ready", 64'(issue_ready_o), 64'(q.size() != N));
        chk("trans_id", 64'(issue_trans_id_o), 64'(nid));
        chk("commit_valid", 64'(commit_valid_o), 64'(cv));
        if (cv) begin
            chk("commit_id", 64'(ce.trans_id), 64'(q[0].id));
            chk("commit_rd", 64'(ce.rd), 64'(q[0].rd));
            chk("commit_pc", ce.pc, q[0].pc);
            chk("commit_result", ce.result, q[0].res);
            chk("commit_exv", 64'(ce.ex.valid), 64'(q[0].ex.valid));
            chk("commit_cause", ce.ex.cause, q[0].ex.cause);
        end
        fwd_exp(rs1_i, v, ok);
        chk("rs1_val", rs1_o, v);
        chk("rs1_ok", 64'(rs1_valid_o), 64'(ok));
        fwd_exp(rs2_i, v, ok);
        chk("rs2_val", rs2_o, v);
        chk("rs2_ok", 64'(rs2_valid_o), 64'(ok));
    endtask

    // One clock: model applies flush, else writeback, then commit, then issue on pre-edge state.
    task automatic tick();
        bit cv, rdy;
        m_t e;
        cv  = q.size() > 0 && q[0].vld;
        rdy = q.size() != N;
        @(posedge clk_i);
        if (flush_i) begin
            q.delete();
            nid = 0;
        end else begin
            for (int k = W - 1; k >= 0; k--)
                if (wb_valid_i[k])
                    foreach (q[i])
                        if (q[i].id == int'(wb_trans_id_i[k])) begin
                            q[i].res = wb_result_i[k];
                            q[i].vld = 1;
                            if (wb_ex_i[k].valid) q[i].ex = wb_ex_i[k];
                        end
            if (commit_ack_i && cv) void'(q.pop_front());
            if (issue_valid_i && rdy) begin
                e.id = nid; e.rd = ie.rd; e.pc = ie.pc; e.res = ie.result;
                e.vld = ie.ex.valid; e.ex = ie.ex;
                q.push_back(e);
                nid = (nid + 1) % N;
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        logic [63:0] exp_res [3];
        idle();
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_ready", 64'(issue_ready_o), 1);
        chk("rst_tid", 64'(issue_trans_id_o), 0);
        chk("rst_cvalid", 64'(commit_valid_o), 0);
        chk("rst_entry_zero", 64'(|ce), 0);
        chk("rst_rs1", rs1_o, 0);
        chk("rst_rs_valid", 64'(rs1_valid_o | rs2_valid_o), 0);
        rst_ni = 1;
        tick();

        // Fill with four entries, no writeback.
        for (int i = 0; i < 4; i++) begin
            idle();
            set_issue(5'(i + 1), 0, 0);
            chk("fill_tid", 64'(issue_trans_id_o), 64'(i));
            tick();
        end
        idle();
        chk("full_ready", 64'(issue_ready_o), 0);
        chk("full_cvalid", 64'(commit_valid_o), 0);

        // Out-of-order writeback to IDs 2,1,0, in-order commit.
        set_wb(0, 2, 64'hA); set_wb(1, 1, 64'hB); set_wb(2, 0, 64'hC);
        tick();
        idle();
        chk("wb_cvalid", 64'(commit_valid_o), 1);
        exp_res = '{64'hC, 64'hB, 64'hA};
        for (int i = 0; i < 3; i++) begin
            idle();
            commit_ack_i = 1;
            chk("commit_order", ce.result, exp_res[i]);
            tick();
        end
        idle();
        chk("pending_4th", 64'(commit_valid_o), 0);
        set_wb(0, 3, 64'hD);
        tick();
        idle();
        commit_ack_i = 1;
        chk("commit_4th", ce.result, 64'hD);
        tick();

        // Full buffer with commit and issue in the same cycle.
        for (int i = 0; i < 4; i++) begin
            idle();
            set_issue(5'(i + 1), 0, 0);
            tick();
        end
        idle();
        set_wb(1, 0, 64'h11);
        tick();
        idle();
        commit_ack_i = 1;
        set_issue(5'd9, 0, 0);
        chk("fc_ready", 64'(issue_ready_o), 0);
        tick();
        idle();
        chk("fc_ready_after", 64'(issue_ready_o), 1);
        chk("fc_wrap_tid", 64'(issue_trans_id_o), 0);
        set_issue(5'd9, 0, 0);
        tick();
        idle();
        chk("fc_full_again", 64'(issue_ready_o), 0);
        flush_i = 1;
        tick();

        // Decode exception commits without writeback.
        idle();
        set_issue(5'd7, 1, ILLEGAL_INSTR);
        tick();
        idle();
        chk("ex_cvalid", 64'(commit_valid_o), 1);
        chk("ex_cause", ce.ex.cause, 64'd2);
        commit_ack_i = 1;
        tick();

        // Flush beats concurrent issue and writeback.
        for (int i = 0; i < 3; i++) begin
            idle();
            set_issue(5'(i + 10), 0, 0);
            tick();
        end
        idle();
        flush_i = 1;
        set_wb(0, 1, 64'h99);
        set_issue(5'd3, 0, 0);
        tick();
        idle();
        chk("flush_tid", 64'(issue_trans_id_o), 0);
        chk("flush_cvalid", 64'(commit_valid_o), 0);
        chk("flush_ready", 64'(issue_ready_o), 1);
        set_wb(0, 1, 64'h77);
        tick();
        idle();
        chk("stale_wb_ignored", 64'(commit_valid_o), 0);
        set_issue(5'd4, 0, 0);
        tick();
        idle();
        chk("post_flush_cvalid", 64'(commit_valid_o), 0);
        flush_i = 1;
        tick();

        // Two entries with rd=5, younger written back.
        for (int i = 0; i < 2; i++) begin
            idle();
            set_issue(5'd5, 0, 0);
            tick();
        end
        idle();
        set_wb(2, 1, 64'h55);
        tick();
        idle();
        rs1_i = 5; rs2_i = 0;
        #1;
`ifdef SB_FORWARD_EN
        chk("fwd_val", rs1_o, 64'h55);
        chk("fwd_ok", 64'(rs1_valid_o), 1);
`else
        chk("fwd_off_val", rs1_o, 0);
        chk("fwd_off_ok", 64'(rs1_valid_o), 0);
`endif
        chk("fwd_x0", 64'(rs2_valid_o), 0);
        flush_i = 1;
        tick();

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            bit [N-1:0] used;
            idle();
            used = '0;
            if ($urandom_range(0, 2) != 0)
                set_issue(5'($urandom_range(0, 7)), $urandom_range(0, 9) == 0, 64'($urandom_range(0, 15)));
            for (int k = 0; k < W; k++) begin
                int id;
                if ($urandom_range(0, 1) == 0) continue;
                id = (q.size() > 0 && $urandom_range(0, 3) != 0) ?
                     q[$urandom_range(0, q.size() - 1)].id : int'($urandom_range(0, N - 1));
                if (used[id]) continue;
                used[id] = 1;
                set_wb(k, id, {$urandom, $urandom});
                if ($urandom_range(0, 7) == 0) begin
                    wb_ex_i[k].valid = 1;
                    wb_ex_i[k].cause = 64'($urandom_range(0, 15));
                    wb_ex_i[k].tval = 64'($urandom);
                end
            end
            commit_ack_i = $urandom_range(0, 2) != 0;
            flush_i = $urandom_range(0, 39) == 0;
            rs1_i = 5'($urandom_range(0, 7));
            rs2_i = 5'($urandom_range(0, 7));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- In-order issue / out-of-order writeback / in-order commit buffer between decode and commit.
- Accepts decoded scoreboard_entry records and tags each with a transaction ID equal to its slot index.
- Collects results and exceptions from NR_WB_PORTS functional-unit writeback ports.
- Presents the oldest entry to the commit stage once it is valid. Optionally answers operand-forwarding lookups for issue.

Parameters:
- NR_ENTRIES, default NR_SB_ENTRIES (4): slot count; power of two, ≥2.
- NR_WB, default NR_WB_PORTS (3): writeback port count.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  discard all in-flight entries.
- issue_entry_i  in  $bits(scoreboard_entry)  decoded instruction; trans_id/result/valid fields ignored except immediate in result.
- issue_valid_i  in  1  issue request.
- issue_ready_o  out  1  slot free.
- issue_trans_id_o  out  TRANS_ID_BITS  ID the current issue receives (= tail pointer).
- wb_valid_i  in  NR_WB  per-port writeback strobe.
- wb_trans_id_i  in  NR_WB×TRANS_ID_BITS  target slot per port.
- wb_result_i  in  NR_WB×64  result per port.
- wb_ex_i  in  NR_WB×$bits(exception)  exception per port.
- commit_entry_o  out  $bits(scoreboard_entry)  head entry.
- commit_valid_o  out  1  head allocated and valid.
- commit_ack_i  in  1  commit consumes head.
- rs1_i, rs2_i  in  5 each  forwarding lookup register addresses.
- rs1_o, rs2_o  out  64 each  forwarded value.
- rs1_valid_o, rs2_valid_o  out  1 each  forwarded value usable.

Behaviour:
- State: head, tail (TRANS_ID_BITS, wrap modulo NR_ENTRIES), count (0..NR_ENTRIES), entry array, per-slot allocated bit.
- Reset: head=tail=count=0; all allocated/valid bits 0.
  - Outputs in reset: issue_ready_o=1, issue_trans_id_o=0, commit_valid_o=0, rs*_valid_o=0, rs*_o=0.
  - commit_entry_o is slot 0, all zero.
- issue_ready_o = (count != NR_ENTRIES). Combinational on count only; a same-cycle commit does not free a slot for issue.
- Issue (issue_valid_i && issue_ready_o):
  - Slot[tail] ← issue_entry_i with trans_id=tail; allocated=1; tail++.
  - valid = issue_entry_i.ex.valid, so fetch/decode exceptions commit without writeback.
- Writeback, per port k with wb_valid_i[k] and slot[wb_trans_id_i[k]] allocated:
  - result ← wb_result_i[k]; valid ← 1.
  - If wb_ex_i[k].valid, ex ← wb_ex_i[k].
  - Writeback to an unallocated slot is ignored.
  - Two ports targeting the same slot in one cycle: lowest k wins (protocol violation; assertion).
- Commit:
  - commit_entry_o = slot[head], combinational.
  - commit_valid_o = allocated[head] && slot[head].valid.
  - commit_ack_i while commit_valid_o: allocated[head]←0, valid←0, head++.
  - Ack without commit_valid_o is ignored.
- A writeback visible on commit_valid_o arrives one cycle after wb_valid_i; there is no writeback→commit bypass.
- count: +1 on issue, −1 on commit, unchanged on both.
- Full-and-commit cycle: commit proceeds, issue is blocked, issue_ready_o=1 the next cycle.
- flush_i: next cycle head=tail=count=0 and all allocated/valid bits are 0.
  - Takes priority over same-cycle issue, writeback and commit; all of them are dropped.
  - issue_ready_o stays combinational on count during the flush cycle.

Optional Feature:
- SB_FORWARD_EN defined, for each rsN_i ≠ 0:
  - Search allocated slots youngest-first (tail−1 down to head) for rd == rsN_i.
  - First match: rsN_o = its result, rsN_valid_o = its valid && !ex.valid.
  - No match, or rsN_i == 0: rsN_o=0, rsN_valid_o=0.
  - Same-cycle writeback is not forwarded.
- SB_FORWARD_EN undefined: rs*_o tied 0, rs*_valid_o tied 0, no search logic synthesised.

Test Plan:
- Issue 4 entries (rd=1..4) with no writeback → trans_ids 0,1,2,3; issue_ready_o=0 after the 4th; commit_valid_o=0.
- Writeback IDs 2,1,0 on ports 0,1,2 in the same cycle with results 0xA,0xB,0xC → commit_valid_o=1 next cycle; 3 acks commit results 0xC,0xB,0xA in order; the 4th stays pending.
- Full buffer, head valid, commit_ack_i=1 with issue_valid_i=1 → commit occurs, no issue that cycle; issue accepted next cycle with trans_id=0 (wrap).
- Issue an entry with ex.valid=1, cause=ILLEGAL_INSTR → commit_valid_o=1 the following cycle with no writeback; commit_entry_o.ex.cause=2.
- 3 entries in flight, flush_i asserted together with a writeback and an issue → next cycle count=0, issue_trans_id_o=0, commit_valid_o=0; a later writeback to old ID 1 is ignored.
- SB_FORWARD_EN: two entries both rd=5, the younger written back with 0x55 → rs1_i=5 gives rs1_o=0x55, rs1_valid_o=1; rs1_i=0 gives rs1_valid_o=0.
